// File: rtl/systolic_array_pkg.sv
// Shared constants for the 3x3 weight-stationary systolic array.
package systolic_array_pkg;
  localparam int DW = 8;
  localparam logic [1:0] SEL_C11 = 2'b00;
  localparam logic [1:0] SEL_C12 = 2'b01;
  localparam logic [1:0] SEL_C21 = 2'b10;
  localparam logic [1:0] SEL_C22 = 2'b11;
endpackage

// File: rtl/systolic_array_pe.sv
// One processing element: stationary weight, forwarded activation, MAC psum.
module systolic_pe
  import systolic_array_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en_a,
  input  logic          en_w,
  input  logic [DW-1:0] w_in,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] p_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] p_out
);
  logic [DW-1:0] w_q, w_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] p_q, p_d;

  // MAC uses the weight held before this edge; a same-cycle load lands next.
  always_comb begin
    w_d = w_q;
    a_d = a_q;
    p_d = p_q;
    if (en_w) w_d = w_in;
    if (en_a) begin
      a_d = a_in;
      p_d = p_in + a_in * w_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
      a_q <= '0;
      p_q <= '0;
    end else begin
      w_q <= w_d;
      a_q <= a_d;
      p_q <= p_d;
    end
  end

  assign a_out = a_q;
  assign p_out = p_q;
endmodule

// File: rtl/systolic_array.sv
// 3x3 systolic MAC array; column-1 bottom sum steered into four result regs.
module systolic_array
  import systolic_array_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en_reg_A,
  input  logic [8:0]    en_reg_B,
  input  logic          en_reg_Acc,
  input  logic [DW-1:0] B11,
  input  logic [DW-1:0] B12,
  input  logic [DW-1:0] B13,
  input  logic [DW-1:0] B21,
  input  logic [DW-1:0] B22,
  input  logic [DW-1:0] B23,
  input  logic [DW-1:0] B31,
  input  logic [DW-1:0] B32,
  input  logic [DW-1:0] B33,
  input  logic [DW-1:0] row1_in,
  input  logic [DW-1:0] row2_in,
  input  logic [DW-1:0] row3_in,
  input  logic [1:0]    sel_en_demux_result,
  input  logic [1:0]    sel_en_demux_c_reg,
  input  logic          input_demux_c_reg,
  output logic [DW-1:0] c11,
  output logic [DW-1:0] c12,
  output logic [DW-1:0] c21,
  output logic [DW-1:0] c22
);
  logic [DW-1:0] w_in  [9];
  logic [DW-1:0] a_lnk [3][4];
  logic [DW-1:0] p_lnk [4][3];
  logic [DW-1:0] p_bot;
  logic [DW-1:0] c_q [4];
  logic [DW-1:0] c_d [4];

  assign w_in[0] = B11;
  assign w_in[1] = B12;
  assign w_in[2] = B13;
  assign w_in[3] = B21;
  assign w_in[4] = B22;
  assign w_in[5] = B23;
  assign w_in[6] = B31;
  assign w_in[7] = B32;
  assign w_in[8] = B33;

  assign a_lnk[0][0] = row1_in;
  assign a_lnk[1][0] = row2_in;
  assign a_lnk[2][0] = row3_in;

  for (genvar c = 0; c < 3; c++) begin : g_top
    assign p_lnk[0][c] = '0;
  end

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      systolic_pe u_pe (
        .clk   (clk),
        .rst   (rst),
        .en_a  (en_reg_A),
        .en_w  (en_reg_B[r*3+c]),
        .w_in  (w_in[r*3+c]),
        .a_in  (a_lnk[r][c]),
        .p_in  (p_lnk[r][c]),
        .a_out (a_lnk[r][c+1]),
        .p_out (p_lnk[r+1][c])
      );
    end
  end

  assign p_bot = p_lnk[3][0];

  always_comb begin
    for (int i = 0; i < 4; i++) c_d[i] = c_q[i];
    if (input_demux_c_reg) begin
      unique case (sel_en_demux_result)
        SEL_C11: c_d[0] = en_reg_Acc ? c_q[0] + p_bot : p_bot;
        SEL_C12: c_d[1] = en_reg_Acc ? c_q[1] + p_bot : p_bot;
        SEL_C21: c_d[2] = en_reg_Acc ? c_q[2] + p_bot : p_bot;
        SEL_C22: c_d[3] = en_reg_Acc ? c_q[3] + p_bot : p_bot;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) c_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) c_q[i] <= c_d[i];
    end
  end

  assign c11 = c_q[0];
  assign c12 = c_q[1];
  assign c21 = c_q[2];
  assign c22 = c_q[3];

  // The controller's companion select is redundant; catch it drifting.
  a_sel_match: assert property (@(posedge clk) disable iff (rst)
    input_demux_c_reg |-> (sel_en_demux_c_reg == sel_en_demux_result));
endmodule

// File: tb/tb_systolic_array.sv
// Bench for systolic_array: directed plan plus random traffic vs a sum model.
module tb_systolic_array;
  logic       clk = 1'b0;
  logic       rst;
  logic       en_reg_A;
  logic [8:0] en_reg_B;
  logic       en_reg_Acc;
  logic [7:0] b [9];
  logic [7:0] row1_in, row2_in, row3_in;
  logic [1:0] sel_r, sel_c;
  logic       cap;
  logic [7:0] c11, c12, c21, c22;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: weights, per-row product history (index 0 newest), results.
  logic [7:0] m_w [9];
  logic [7:0] h1 [3];
  logic [7:0] h2 [3];
  logic [7:0] h3 [3];
  logic [7:0] m_p;
  logic [7:0] m_c [4];

  always #5 clk = ~clk;

  systolic_array dut (
    .clk                 (clk),
    .rst                 (rst),
    .en_reg_A            (en_reg_A),
    .en_reg_B            (en_reg_B),
    .en_reg_Acc          (en_reg_Acc),
    .B11                 (b[0]),
    .B12                 (b[1]),
    .B13                 (b[2]),
    .B21                 (b[3]),
    .B22                 (b[4]),
    .B23                 (b[5]),
    .B31                 (b[6]),
    .B32                 (b[7]),
    .B33                 (b[8]),
    .row1_in             (row1_in),
    .row2_in             (row2_in),
    .row3_in             (row3_in),
    .sel_en_demux_result (sel_r),
    .sel_en_demux_c_reg  (sel_c),
    .input_demux_c_reg   (cap),
    .c11                 (c11),
    .c12                 (c12),
    .c21                 (c21),
    .c22                 (c22)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_w[i] = 8'd0;
    for (int i = 0; i < 3; i++) begin
      h1[i] = 8'd0;
      h2[i] = 8'd0;
      h3[i] = 8'd0;
    end
    for (int i = 0; i < 4; i++) m_c[i] = 8'd0;
    m_p = 8'd0;
  endtask

  task automatic step(input logic r, input logic ea, input logic [8:0] eb,
                      input logic acc, input logic [1:0] sel,
                      input logic cp, input logic [7:0] x1,
                      input logic [7:0] x2, input logic [7:0] x3);
    rst = r; en_reg_A = ea; en_reg_B = eb; en_reg_Acc = acc;
    sel_r = sel; sel_c = sel; cap = cp;
    row1_in = x1; row2_in = x2; row3_in = x3;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (cp) m_c[sel] = acc ? m_c[sel] + m_p : m_p;
      if (ea) begin
        // A column-1 sum is a1*w11 two enabled edges ago, a2*w21 one ago, a3*w31 now.
        for (int i = 2; i > 0; i--) begin
          h1[i] = h1[i-1];
          h2[i] = h2[i-1];
          h3[i] = h3[i-1];
        end
        h1[0] = x1 * m_w[0];
        h2[0] = x2 * m_w[3];
        h3[0] = x3 * m_w[6];
        m_p = h1[2] + h2[1] + h3[0];
      end
      for (int k = 0; k < 9; k++) if (eb[k]) m_w[k] = b[k];
    end
    #1;
    chk("c11", c11, m_c[0]);
    chk("c12", c12, m_c[1]);
    chk("c21", c21, m_c[2]);
    chk("c22", c22, m_c[3]);
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 9'h0, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic feed(input logic [7:0] x1, input logic [7:0] x2,
                      input logic [7:0] x3, input logic [1:0] sel,
                      input logic acc);
    step(1'b0, 1'b1, 9'h0, acc, sel, 1'b0, x1, 8'd0, 8'd0);
    step(1'b0, 1'b1, 9'h0, acc, sel, 1'b0, 8'd0, x2, 8'd0);
    step(1'b0, 1'b1, 9'h0, acc, sel, 1'b0, 8'd0, 8'd0, x3);
    step(1'b0, 1'b1, 9'h0, acc, sel, 1'b1, 8'd0, 8'd0, 8'd0);
  endtask

  initial begin
    logic [7:0] rv [3];
    for (int i = 0; i < 9; i++) b[i] = 8'd0;
    rst = 1'b1; en_reg_A = 1'b0; en_reg_B = 9'h0; en_reg_Acc = 1'b0;
    sel_r = 2'b00; sel_c = 2'b00; cap = 1'b0;
    row1_in = 8'd0; row2_in = 8'd0; row3_in = 8'd0;
    model_reset();

    // Reset with capture and enables asserted must still keep results at 0.
    step(1'b1, 1'b1, 9'h1FF, 1'b1, 2'b00, 1'b1, 8'd9, 8'd9, 8'd9);
    step(1'b1, 1'b0, 9'h0, 1'b0, 2'b11, 1'b1, 8'd0, 8'd0, 8'd0);
    chk("reset_c11", c11, 8'd0);
    chk("reset_c22", c22, 8'd0);

    for (int r = 0; r < 3; r++) begin
      b[r*3+0] = 8'd1;
      b[r*3+1] = 8'd2;
      b[r*3+2] = 8'd3;
    end
    step(1'b0, 1'b0, 9'h1FF, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0, 8'd0);
    step(1'b0, 1'b0, 9'h000, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0, 8'd0);

    feed(8'd1, 8'd2, 8'd3, 2'b00, 1'b0);
    chk("plan2_c11", c11, 8'd6);
    chk("plan2_c12", c12, 8'd0);

    feed(8'd2, 8'd3, 8'd4, 2'b01, 1'b0);
    chk("plan3_c12", c12, 8'd9);
    chk("plan3_c11", c11, 8'd6);

    feed(8'd1, 8'd2, 8'd3, 2'b11, 1'b1);
    idle();
    feed(8'd1, 8'd2, 8'd3, 2'b11, 1'b1);
    chk("plan4_c22", c22, 8'd12);

    b[0] = 8'd200; b[3] = 8'd100; b[6] = 8'd0;
    step(1'b0, 1'b0, 9'b001001001, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0, 8'd0);
    feed(8'd2, 8'd1, 8'd0, 2'b00, 1'b0);
    chk("plan5_wrap", c11, 8'd244);

    // Load with en_reg_A high: the PE must use the old weight this cycle.
    b[0] = 8'd1; b[3] = 8'd1; b[6] = 8'd1;
    step(1'b0, 1'b1, 9'b001001001, 1'b0, 2'b00, 1'b0, 8'd5, 8'd0, 8'd0);
    step(1'b0, 1'b1, 9'h0, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0, 8'd0);
    step(1'b0, 1'b1, 9'h0, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0, 8'd0);
    step(1'b0, 1'b1, 9'h0, 1'b0, 2'b10, 1'b1, 8'd0, 8'd0, 8'd0);
    chk("old_weight_c21", c21, 8'd232);

    // Freeze mid-stream: garbage inputs while en_reg_A=0 must not matter.
    step(1'b0, 1'b1, 9'h0, 1'b0, 2'b00, 1'b0, 8'd1, 8'd0, 8'd0);
    step(1'b0, 1'b0, 9'h0, 1'b0, 2'b00, 1'b0, 8'd7, 8'd7, 8'd7);
    step(1'b0, 1'b0, 9'h0, 1'b0, 2'b00, 1'b0, 8'd9, 8'd9, 8'd9);
    chk("frozen_c11", c11, 8'd244);
    step(1'b0, 1'b1, 9'h0, 1'b0, 2'b00, 1'b0, 8'd0, 8'd2, 8'd0);
    step(1'b0, 1'b1, 9'h0, 1'b0, 2'b00, 1'b0, 8'd0, 8'd0, 8'd3);
    step(1'b0, 1'b0, 9'h0, 1'b0, 2'b00, 1'b1, 8'd0, 8'd0, 8'd0);
    chk("resume_c11", c11, 8'd6);

    // Reset mid-stream flushes partial sums too.
    step(1'b0, 1'b1, 9'h0, 1'b0, 2'b00, 1'b0, 8'd4, 8'd0, 8'd0);
    step(1'b0, 1'b1, 9'h0, 1'b0, 2'b00, 1'b0, 8'd0, 8'd4, 8'd0);
    step(1'b1, 1'b1, 9'h0, 1'b0, 2'b00, 1'b1, 8'd0, 8'd0, 8'd4);
    chk("midrst_c11", c11, 8'd0);
    chk("midrst_c12", c12, 8'd0);
    chk("midrst_c22", c22, 8'd0);
    step(1'b0, 1'b1, 9'h0, 1'b1, 2'b01, 1'b1, 8'd0, 8'd0, 8'd0);
    chk("flushed_c12", c12, 8'd0);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 9; i++) b[i] = 8'($urandom);
      for (int i = 0; i < 3; i++) rv[i] = 8'($urandom);
      step(($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) != 0),
           (($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h0),
           1'($urandom), 2'($urandom), 1'($urandom),
           rv[0], rv[1], rv[2]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
